sync_fifo_pack: RTL

//  Single-clock, parametrised width-packing FIFO in plain RTL (no vendor IP).
//  - Accepts WR_W-bit words; packs every RATIO consecutive writes into one RD_W = WR_W*RATIO read word.
//  - Provides occupancy counts, almost_full/almost_empty thresholds, synchronous flush and sticky overflow/underflow flags.
//  - Generalised single-clock successor of the fixed 8->16 bit dual-clock FIFO wrapper, for byte-to-word datapaths.

---
 rtl/sync_fifo_pack.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sync_fifo_pack.sv
// Single-clock width-packing FIFO: RATIO consecutive WR_W writes form one RD_W read word.
// Partial packs sit in a lane register and only become readable once committed to memory.
module sync_fifo_pack #(
    parameter int unsigned WR_W      = 8,
    parameter int unsigned RATIO     = 2,
    parameter int unsigned RD_DEPTH  = 128,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned AF_THRESH = 240,
    parameter int unsigned AE_THRESH = 2,
    localparam int unsigned RD_W     = WR_W * RATIO,
    localparam int unsigned WC_W     = $clog2(RD_DEPTH * RATIO + RATIO),
    localparam int unsigned RC_W     = $clog2(RD_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            wr_en,
    input  logic [WR_W-1:0] wr_data,
    input  logic            rd_en,
    output logic [RD_W-1:0] rd_data,
    output logic            full,
    output logic            empty,
    output logic            almost_full,
    output logic            almost_empty,
    output logic [WC_W-1:0] wr_data_count,
    output logic [RC_W-1:0] rd_data_count,
    output logic            overflow,
    output logic            underflow
);

    localparam int unsigned AW = $clog2(RD_DEPTH);
    localparam int unsigned LW = $clog2(RATIO);

    localparam logic [LW-1:0]   LAST_LANE = LW'(RATIO - 1);
    localparam logic [RC_W-1:0] DEPTH_CNT = RC_W'(RD_DEPTH);
    localparam logic [WC_W-1:0] AF_LIM    = WC_W'(AF_THRESH);
    localparam logic [RC_W-1:0] AE_LIM    = RC_W'(AE_THRESH);

    logic [RD_W-1:0] mem [RD_DEPTH];

    logic [RATIO-2:0][WR_W-1:0] pack_q, pack_d;
    logic [LW-1:0]              lane_q, lane_d;
    logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [RC_W-1:0]            cnt_q, cnt_d;
    logic [RD_W-1:0]            rd_data_q, rd_data_d;
    logic                       overflow_q, overflow_d;
    logic                       underflow_q, underflow_d;

    logic            wr_acc;
    logic            rd_acc;
    logic            commit;
    logic [RD_W-1:0] commit_word;

    assign full          = (cnt_q == DEPTH_CNT) && (lane_q == LAST_LANE);
    assign empty         = (cnt_q == '0);
    assign wr_data_count = WC_W'(cnt_q) * WC_W'(RATIO) + WC_W'(lane_q);
    assign rd_data_count = cnt_q;
    assign almost_full   = (wr_data_count >= AF_LIM);
    assign almost_empty  = (cnt_q <= AE_LIM);
    assign rd_data       = rd_data_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

    // flush masks both strobes so nothing is stored or read in the flush cycle
    assign wr_acc = wr_en && !full && !flush;
    assign rd_acc = rd_en && !empty && !flush;
    assign commit = wr_acc && (lane_q == LAST_LANE);

    // Lane i is the i-th written word of the pack; the incoming word is always the last lane.
    always_comb begin
        commit_word = '0;
        for (int i = 0; i < int'(RATIO) - 1; i++) begin
            if (MSB_FIRST) begin
                commit_word[(int'(RATIO) - 1 - i) * int'(WR_W) +: WR_W] = pack_q[i];
            end else begin
                commit_word[i * int'(WR_W) +: WR_W] = pack_q[i];
            end
        end
        if (MSB_FIRST) begin
            commit_word[WR_W-1:0] = wr_data;
        end else begin
            commit_word[RD_W-1 -: WR_W] = wr_data;
        end
    end

    always_comb begin
        pack_d      = pack_q;
        lane_d      = lane_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        rd_data_d   = rd_data_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            lane_d      = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            cnt_d       = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                if (commit) begin
                    lane_d   = '0;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end else begin
                    for (int i = 0; i < int'(RATIO) - 1; i++) begin
                        if (lane_q == LW'(i)) begin
                            pack_d[i] = wr_data;
                        end
                    end
                    lane_d = lane_q + LW'(1);
                end
            end

            if (rd_acc) begin
                rd_ptr_d  = rd_ptr_q + AW'(1);
                rd_data_d = mem[rd_ptr_q];
            end

            if (commit && !rd_acc) begin
                cnt_d = cnt_q + RC_W'(1);
            end else if (rd_acc && !commit) begin
                cnt_d = cnt_q - RC_W'(1);
            end

            if (wr_en && full) begin
                overflow_d = 1'b1;
            end
            if (rd_en && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Storage has no reset: contents are don't-care until committed again.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wr_ptr_q] <= commit_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_q      <= '0;
            lane_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            rd_data_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pack_q      <= pack_d;
            lane_q      <= lane_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            rd_data_q   <= rd_data_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule
